// File: rtl/best_hash_tracker_pkg.sv
// Shared constants and state encoding for the best-hash tracker.
// Defaults assume a 1024-bit hash and 64-bit candidate nonces.
package best_hash_tracker_pkg;

    localparam int HASH_BITS            = 1024;
    localparam int DEFAULT_COUNT_WIDTH  = $clog2(HASH_BITS + 1);
    localparam int DEFAULT_NONCE_WIDTH  = 64;
    localparam int DEFAULT_RESULT_WIDTH = 32;

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_REPORT = 1'b1;

    localparam logic [DEFAULT_COUNT_WIDTH-1:0] BEST_INIT = '1;

    typedef enum logic {
        IDLE   = STATE_IDLE,
        REPORT = STATE_REPORT
    } state_t;

endpackage

// File: rtl/best_hash_report_fsm.sv
// Report-channel controller: IDLE/REPORT state plus a one-deep pending flag.
// Ports: clk_i, rst_i, reportable_i, ready_i in; valid_o, load_in_o, load_pend_o out.
module best_hash_report_fsm
    import best_hash_tracker_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic reportable_i,
    input  logic ready_i,
    output logic valid_o,
    output logic load_in_o,
    output logic load_pend_o
);

    state_t state, state_nxt;
    logic   pending, pending_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        valid_o     = 1'b0;
        load_in_o   = 1'b0;
        load_pend_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (reportable_i) begin
                    load_in_o = 1'b1;
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    pending_nxt = 1'b0;
                    // A result arriving on the handshake cycle is newer
                    // than anything pending, so it wins.
                    if (reportable_i)
                        load_in_o = 1'b1;
                    else if (pending)
                        load_pend_o = 1'b1;
                    else
                        state_nxt = IDLE;
                end else if (reportable_i) begin
                    pending_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/best_hash_tracker.sv
// Running-minimum tracker of hash bits-off counts with a valid/ready report channel.
// Ports: clk_i, rst_i, result_valid_i, bits_off_i, nonce_i, clear_i, report_ready_i in;
//        best_bits_off_o, best_nonce_o, report_valid_o, report_bits_off_o,
//        report_nonce_o, result_count_o out.
// Option BEST_HASH_THRESHOLD_EN adds report_threshold_i; only bests at or
// below the threshold are reported.
module best_hash_tracker
    import best_hash_tracker_pkg::*;
#(
    parameter int COUNT_WIDTH      = DEFAULT_COUNT_WIDTH,
    parameter int NONCE_WIDTH      = DEFAULT_NONCE_WIDTH,
    parameter int RESULT_CNT_WIDTH = DEFAULT_RESULT_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        result_valid_i,
    input  logic [COUNT_WIDTH-1:0]      bits_off_i,
    input  logic [NONCE_WIDTH-1:0]      nonce_i,
    input  logic                        clear_i,
`ifdef BEST_HASH_THRESHOLD_EN
    input  logic [COUNT_WIDTH-1:0]      report_threshold_i,
`endif
    output logic [COUNT_WIDTH-1:0]      best_bits_off_o,
    output logic [NONCE_WIDTH-1:0]      best_nonce_o,
    output logic                        report_valid_o,
    input  logic                        report_ready_i,
    output logic [COUNT_WIDTH-1:0]      report_bits_off_o,
    output logic [NONCE_WIDTH-1:0]      report_nonce_o,
    output logic [RESULT_CNT_WIDTH-1:0] result_count_o
);

    localparam logic [COUNT_WIDTH-1:0] ALL_ONES = '1;

    logic [COUNT_WIDTH-1:0] eff_best;
    logic [COUNT_WIDTH-1:0] pend_bits;
    logic [NONCE_WIDTH-1:0] pend_nonce;
    logic                   improved;
    logic                   reportable;
    logic                   load_in;
    logic                   load_pend;

    // A same-cycle clear lets the incoming result compete against a fresh slate.
    assign eff_best = clear_i ? ALL_ONES : best_bits_off_o;
    assign improved = result_valid_i && (bits_off_i < eff_best);

`ifdef BEST_HASH_THRESHOLD_EN
    assign reportable = improved && (bits_off_i <= report_threshold_i);
`else
    assign reportable = improved;
`endif

    best_hash_report_fsm u_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .reportable_i (reportable),
        .ready_i      (report_ready_i),
        .valid_o      (report_valid_o),
        .load_in_o    (load_in),
        .load_pend_o  (load_pend)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            best_bits_off_o   <= ALL_ONES;
            best_nonce_o      <= '0;
            report_bits_off_o <= '0;
            report_nonce_o    <= '0;
            pend_bits         <= '0;
            pend_nonce        <= '0;
            result_count_o    <= '0;
        end else begin
            if (improved) begin
                best_bits_off_o <= bits_off_i;
                best_nonce_o    <= nonce_i;
            end else if (clear_i) begin
                best_bits_off_o <= ALL_ONES;
                best_nonce_o    <= '0;
            end
            if (result_valid_i)
                result_count_o <= result_count_o + RESULT_CNT_WIDTH'(1);
            // Pending copy is separate from best_* so a later clear cannot
            // corrupt a report that is already queued.
            if (reportable) begin
                pend_bits  <= bits_off_i;
                pend_nonce <= nonce_i;
            end
            if (load_in) begin
                report_bits_off_o <= bits_off_i;
                report_nonce_o    <= nonce_i;
            end else if (load_pend) begin
                report_bits_off_o <= pend_bits;
                report_nonce_o    <= pend_nonce;
            end
        end
    end

endmodule

// File: tb/tb_best_hash_tracker.sv
// Scoreboard bench for best_hash_tracker: a channel-level reference model
// predicts the visible state after every clock; a monitor compares it.
module tb_best_hash_tracker;

    localparam int CW = 11;
    localparam int NW = 64;
    localparam int RW = 32;
    localparam int unsigned ONES = 2047;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic          result_valid_i = 1'b0;
    logic [CW-1:0] bits_off_i = '0;
    logic [NW-1:0] nonce_i = '0;
    logic          clear_i = 1'b0;
    logic          report_ready_i = 1'b0;
    logic [CW-1:0] thr = '1;
    logic [CW-1:0] best_bits_off_o;
    logic [NW-1:0] best_nonce_o;
    logic          report_valid_o;
    logic [CW-1:0] report_bits_off_o;
    logic [NW-1:0] report_nonce_o;
    logic [RW-1:0] result_count_o;

    best_hash_tracker dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .result_valid_i    (result_valid_i),
        .bits_off_i        (bits_off_i),
        .nonce_i           (nonce_i),
        .clear_i           (clear_i),
`ifdef BEST_HASH_THRESHOLD_EN
        .report_threshold_i(thr),
`endif
        .best_bits_off_o   (best_bits_off_o),
        .best_nonce_o      (best_nonce_o),
        .report_valid_o    (report_valid_o),
        .report_ready_i    (report_ready_i),
        .report_bits_off_o (report_bits_off_o),
        .report_nonce_o    (report_nonce_o),
        .result_count_o    (result_count_o)
    );

    typedef struct {
        int unsigned best;
        logic [NW-1:0] bn;
        logic [RW-1:0] cnt;
        bit rv;
        int unsigned rb;
        logic [NW-1:0] rn;
    } rec_t;

    rec_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: best value, one offered report slot, one newest-pending slot.
    int unsigned   m_best = ONES;
    logic [NW-1:0] m_bn = '0;
    logic [RW-1:0] m_cnt = '0;
    bit            m_rv = 0;
    int unsigned   m_rb = 0;
    logic [NW-1:0] m_rn = '0;
    bit            m_pv = 0;
    int unsigned   m_pb = 0;
    logic [NW-1:0] m_pn = '0;

    task automatic model_step(input bit r, input bit v, input int unsigned b,
                              input logic [NW-1:0] n, input bit c, input bit rdy);
        int unsigned eff;
        bit imp, rep, hs;
        if (r) begin
            m_best = ONES; m_bn = '0; m_cnt = '0;
            m_rv = 0; m_rb = 0; m_rn = '0;
            m_pv = 0; m_pb = 0; m_pn = '0;
            return;
        end
        eff = c ? ONES : m_best;
        imp = v && (b < eff);
        rep = imp && (b <= int'(thr));
        hs  = m_rv && rdy;
        if (imp) begin
            m_best = b; m_bn = n;
        end else if (c) begin
            m_best = ONES; m_bn = '0;
        end
        if (v) m_cnt = m_cnt + 1;
        if (hs || !m_rv) begin
            if (rep) begin
                m_rv = 1; m_rb = b; m_rn = n;
            end else if (m_pv) begin
                m_rv = 1; m_rb = m_pb; m_rn = m_pn;
            end else begin
                m_rv = 0;
            end
            m_pv = 0;
        end else if (rep) begin
            m_pv = 1; m_pb = b; m_pn = n;
        end
    endtask

    task automatic step(input bit r, input bit v, input int unsigned b,
                        input logic [NW-1:0] n, input bit c, input bit rdy);
        rec_t e;
        @(negedge clk);
        rst_i = r;
        result_valid_i = v;
        bits_off_i = b[CW-1:0];
        nonce_i = n;
        clear_i = c;
        report_ready_i = rdy;
        model_step(r, v, b, n, c, rdy);
        e.best = m_best; e.bn = m_bn; e.cnt = m_cnt;
        e.rv = m_rv; e.rb = m_rb; e.rn = m_rn;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int k, input bit rdy);
        for (int i = 0; i < k; i++) step(0, 0, 0, '0, 0, rdy);
    endtask

    initial begin : monitor
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (int'(best_bits_off_o) != e.best || best_nonce_o != e.bn ||
                    result_count_o != e.cnt || report_valid_o != e.rv ||
                    (e.rv && (int'(report_bits_off_o) != e.rb ||
                              report_nonce_o != e.rn)) ||
                    (!e.rv && int'(report_bits_off_o) != e.rb)) begin
                    errors++;
                    $display("FAIL state t=%0t got best=%0d/%0h cnt=%0d v=%0b rep=%0d/%0h exp best=%0d/%0h cnt=%0d v=%0b rep=%0d/%0h",
                             $time, best_bits_off_o, best_nonce_o, result_count_o,
                             report_valid_o, report_bits_off_o, report_nonce_o,
                             e.best, e.bn, e.cnt, e.rv, e.rb, e.rn);
                end
            end
        end
    end

    initial begin : stim
        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        // first reports
        step(0, 1, 700, 64'h1, 0, 1);
        step(0, 1, 650, 64'h2, 0, 1);
        idle(2, 1);
        // tie and worse
        step(0, 1, 650, 64'h3, 0, 1);
        step(0, 1, 800, 64'h4, 0, 1);
        idle(1, 1);
        // stalled channel, only newest queued
        step(0, 1, 500, 64'h5, 0, 0);
        step(0, 1, 480, 64'h6, 0, 0);
        step(0, 1, 470, 64'h7, 0, 0);
        idle(3, 0);
        idle(3, 1);
        // handshake coinciding with a new best
        step(0, 1, 420, 64'h8, 0, 0);
        step(0, 1, 400, 64'h9, 0, 1);
        idle(2, 1);
        // clear with and without a result
        step(0, 1, 900, 64'hA, 1, 1);
        idle(2, 1);
        step(0, 0, 0, '0, 1, 1);
        idle(1, 1);
        // reset mid-report
        step(0, 1, 300, 64'hB, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        idle(2, 1);
`ifdef BEST_HASH_THRESHOLD_EN
        thr = 11'd450;
        step(0, 1, 460, 64'hC, 0, 1);
        idle(2, 1);
        step(0, 1, 440, 64'hD, 0, 1);
        idle(2, 1);
        thr = '1;
`endif
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2047),
                 {$urandom, $urandom},
                 ($urandom_range(0, 11) == 0),
                 $urandom_range(0, 2) != 0);
        end
        idle(3, 1);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/best_hash_tracker.md
Name: best_hash_tracker

Overview:
- Sits directly downstream of the hash bits-off stage.
- Consumes each completed bits-off count together with the nonce/input that produced it.
- Keeps the lowest count seen so far (running minimum) and its nonce.
- Emits each new best on a valid/ready report channel to the host-output stage (UART formatter), holding report data stable until it is accepted.

Parameters:
- COUNT_WIDTH, 11, width of bits-off count (0..1024 for a 1024-bit hash).
- NONCE_WIDTH, 64, width of the candidate identifier paired with each count.
- RESULT_CNT_WIDTH, 32, width of the evaluated-results counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- result_valid_i  input  1  one-cycle pulse: bits_off_i/nonce_i valid (driven by upstream done_o).
- bits_off_i  input  COUNT_WIDTH  bits-off count of the completed hash.
- nonce_i  input  NONCE_WIDTH  candidate that produced the hash.
- clear_i  input  1  single-cycle request to forget the current best.
- best_bits_off_o  output  COUNT_WIDTH  current best count.
- best_nonce_o  output  NONCE_WIDTH  nonce of current best.
- report_valid_o  output  1  report channel valid.
- report_ready_i  input  1  report channel ready.
- report_bits_off_o  output  COUNT_WIDTH  reported count.
- report_nonce_o  output  NONCE_WIDTH  reported nonce.
- result_count_o  output  RESULT_CNT_WIDTH  number of results evaluated, wraps.

Behaviour:
- Clock/reset: one clock, clk_i; rst_i synchronous, active-high.
- Reset values:
  - best_bits_off_o = all ones (2047 at default).
  - best_nonce_o = 0; report_bits_off_o = 0; report_nonce_o = 0.
  - report_valid_o = 0; result_count_o = 0; pending flag = 0; state = IDLE.
- Improvement test: improved = result_valid_i && (bits_off_i < effective_best). The comparison is strictly less-than: ties keep the earlier nonce.
- effective_best: all ones if clear_i is asserted the same cycle, else best_bits_off_o.
- On improved, at the next clock edge: best_* <= inputs.
- clear_i without improved: best_bits_off_o <= all ones and best_nonce_o <= 0. An already-queued report is not cancelled.
- result_count_o increments on every result_valid_i pulse, whether or not it improves; wraps to 0 on overflow.
- State IDLE:
  - report_valid_o = 0.
  - On improved: load report_* from inputs, go to REPORT.
  - Latency: result pulse at cycle N gives report_valid_o = 1 at N+1.
- State REPORT:
  - report_valid_o = 1; report_* held stable while valid and not accepted.
  - An improvement arriving here updates best_* immediately and sets pending.
  - Handshake (report_valid_o && report_ready_i), pending = 0 and no improvement this cycle: go to IDLE.
  - Handshake, pending = 1 or improvement this cycle: load report_* from the newest best, clear pending, stay in REPORT. valid stays high, so back-to-back transfers are allowed.
  - Only the newest best is ever queued; intermediate bests superseded while pending are dropped by design.
- Upstream has no backpressure: result_valid_i is never stalled or lost.
- rst_i mid-report drops report_valid_o the next cycle without a handshake; all state returns to reset values.

Optional Feature:
- Macro: BEST_HASH_THRESHOLD_EN.
- Defined:
  - Adds input report_threshold_i [COUNT_WIDTH].
  - An improvement is still tracked in best_*, but is only reported or made pending if bits_off_i <= report_threshold_i.
- Undefined: port absent; every improvement is reportable.

Decomposition:
- Shared package:
  - COUNT_WIDTH default (derived as clog2(HASH_BITS+1)).
  - NONCE_WIDTH default.
  - State encoding localparams STATE_IDLE / STATE_REPORT.
  - BEST_INIT all-ones constant.
- Sub-module: best_hash_report_fsm (IDLE/REPORT state, pending flag, valid/load controls). The datapath registers and comparator stay in the top.

Test Plan:
- After reset, results (700, 0x1) then (650, 0x2), ready = 1 -> reports 700/0x1 then 650/0x2; best = 650; result_count_o = 2.
- Best = 650; results 650 (tie) and 800 -> no report; best stays 650/0x2; result_count_o increments by 2.
- ready = 0; results 500, 480, 470 in successive pulses -> report holds 500 until ready = 1. Then one further report of 470 with valid continuous across the handshake; 480 never reported.
- Handshake coinciding with result 400 -> next cycle report = 400, valid remains 1; no duplicate of the prior value.
- clear_i together with result 900 -> best = 900 and a report of 900 is issued; clear_i alone -> best = 2047/0.
- rst_i asserted while report_valid_o = 1 -> valid 0 next cycle, all outputs at reset values. With BEST_HASH_THRESHOLD_EN and threshold = 450: result 460 tracked in best but not reported; result 440 reported.
